// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO: turns the FIFO's one-cycle registered
// read port into a valid/ready stream, using a 2-entry skid buffer to keep 1 word/cycle.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    logic [1:0][DATA_WIDTH-1:0] buf_q;
    logic                       head, tail;
    logic                       inflight;
    logic                       pop;
    logic [2:0]                 occ;

    assign pop     = m_valid && m_ready;
    assign m_valid = (buf_count != 2'd0);
    assign m_data  = buf_q[head];

    // Reserve a slot for every word already requested; a same-cycle pop frees one.
    assign occ       = {1'b0, buf_count} + {2'b00, inflight};
    assign fifo_r_en = rst_n && !fifo_empty && (occ < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            inflight  <= 1'b0;
            buf_count <= 2'd0;
            rd_count  <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (inflight) begin
                buf_q[tail] <= fifo_data_out;
                tail        <= ~tail;
            end
            if (pop) begin
                head     <= ~head;
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
            buf_count <= buf_count + 2'(inflight) - 2'(pop);
        end
    end

endmodule
